// File: rtl/riscq_dcache.sv
// riscq_dcache
//   Direct-mapped, write-through data cache sitting between the RISCQ core
//   data port and an external single-port synchronous data RAM (1-cycle read
//   latency). After reset the cache owns the RAM port for the loader until
//   i_init_done; then it serves core reads (hit: same cycle, miss: one stall
//   cycle followed by a one-cycle FILL) and writes through every in-region
//   store. Stores never allocate a line; store hits merge their enabled bytes.
//
// Handshake: a core request is valid in any cycle with i_as high. While
//   o_halt is high the core holds every request input stable, and the request
//   completes in the first cycle that sees o_halt low (read data on o_rdata in
//   that same cycle).
//
// Optional feature macro: DCACHE_STATS_EN
//   Defined: adds saturating o_hit_cnt / o_miss_cnt counters.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_addr, i_wdata     core byte address / write data
//   i_be, i_we, i_re    byte enables, write request, read request
//   i_as                access strobe
//   o_rdata, o_halt     read data, core stall
//   i_init_*            loader port (done, write strobe, word address, data)
//   o_ram_*             RAM enable, byte write enables, word address, data
//   i_ram_rdata         RAM read data (valid the cycle after an enabled read)
//   dbg_state           current FSM state (0 INIT, 1 IDLE, 2 FILL)
//   o_hit_cnt, o_miss_cnt  statistics counters (DCACHE_STATS_EN only)

module riscq_dcache #(
   parameter int LINES    = 64,
   parameter int RAM_AW   = 12,
   parameter int SEL_BITS = 2,
   parameter int DATA_SEL = 0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [31:0]       i_addr,
   input  logic [31:0]       i_wdata,
   input  logic [3:0]        i_be,
   input  logic              i_we,
   input  logic              i_re,
   input  logic              i_as,
   output logic [31:0]       o_rdata,
   output logic              o_halt,
   input  logic              i_init_done,
   input  logic              i_init_we,
   input  logic [RAM_AW-1:0] i_init_waddr,
   input  logic [31:0]       i_init_wdata,
   output logic              o_ram_en,
   output logic [3:0]        o_ram_we,
   output logic [RAM_AW-1:0] o_ram_addr,
   output logic [31:0]       o_ram_wdata,
   input  logic [31:0]       i_ram_rdata,
   output logic [1:0]        dbg_state
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]       o_hit_cnt,
   output logic [31:0]       o_miss_cnt
`endif
);

   localparam int IDX   = $clog2(LINES);
   localparam int TAG_W = 30 - IDX;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_FILL = 2'd2
   } state_t;

   state_t state;
   state_t state_nx;

   logic [LINES-1:0] valid;
   logic [TAG_W-1:0] tag_mem  [LINES];
   logic [31:0]      data_mem [LINES];

   logic [IDX-1:0]    idx;
   logic [TAG_W-1:0]  tag;
   logic [RAM_AW-1:0] ram_addr;
   logic              sel;
   logic              hit;
   logic              req_rd;
   logic              req_wr;

   // Line being refilled; captured on the miss cycle so the FILL write does
   // not depend on the core still presenting the address.
   logic [IDX-1:0]   fill_idx;
   logic [TAG_W-1:0] fill_tag;

   // Byte-offset bits carry no meaning for a word cache.
   logic unused_addr_bits;
   assign unused_addr_bits = ^i_addr[1:0];

   assign idx      = i_addr[IDX+1:2];
   assign tag      = i_addr[31:IDX+2];
   assign ram_addr = i_addr[RAM_AW+1:2];
   assign sel      = (i_addr[31 -: SEL_BITS] == SEL_BITS'(DATA_SEL));
   assign hit      = valid[idx] && (tag_mem[idx] == tag);

   // A request with both i_re and i_we is a write.
   assign req_rd = i_as & i_re & ~i_we & sel;
   assign req_wr = i_as & i_we & sel;

   assign dbg_state = state;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= ST_INIT;
      end else begin
         state <= state_nx;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state and all outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_nx    = state;
      o_rdata     = '0;
      o_halt      = 1'b0;
      o_ram_en    = 1'b0;
      o_ram_we    = '0;
      o_ram_addr  = '0;
      o_ram_wdata = '0;
      case (state)
         ST_INIT: begin
            // Loader owns the RAM; the core stalls on any access.
            o_halt = i_as;
            if (i_init_we) begin
               o_ram_en    = 1'b1;
               o_ram_we    = 4'hF;
               o_ram_addr  = i_init_waddr;
               o_ram_wdata = i_init_wdata;
            end
            if (i_init_done) begin
               state_nx = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (req_wr) begin
               // Write-through; i_be == 0 still issues a harmless RAM cycle.
               o_ram_en    = 1'b1;
               o_ram_we    = i_be;
               o_ram_addr  = ram_addr;
               o_ram_wdata = i_wdata;
            end else if (req_rd) begin
               if (hit) begin
                  o_rdata = data_mem[idx];
               end else begin
                  o_halt     = 1'b1;
                  o_ram_en   = 1'b1;
                  o_ram_addr = ram_addr;
                  state_nx   = ST_FILL;
               end
            end
         end
         ST_FILL: begin
            // RAM data arrives now; forward it and release the core.
            o_rdata  = i_ram_rdata;
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_INIT;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Valid bits (the only line state that needs a reset)
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         valid <= '0;
      end else if (state == ST_FILL) begin
         valid[fill_idx] <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Tag / data arrays and fill bookkeeping
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         if (state == ST_FILL) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= i_ram_rdata;
         end else if (state == ST_IDLE) begin
            if (req_wr && hit) begin
               for (int b = 0; b < 4; b++) begin
                  if (i_be[b]) begin
                     data_mem[idx][8*b +: 8] <= i_wdata[8*b +: 8];
                  end
               end
            end
            if (req_rd && !hit) begin
               fill_idx <= idx;
               fill_tag <= tag;
            end
         end
      end
   end

`ifdef DCACHE_STATS_EN
   // ------------------------------------------------------------------
   // Saturating hit / miss counters
   // ------------------------------------------------------------------
   logic hit_evt;
   logic miss_evt;

   assign hit_evt  = (state == ST_IDLE) && req_rd && hit;
   assign miss_evt = (state == ST_IDLE) && (state_nx == ST_FILL);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_hit_cnt  <= '0;
         o_miss_cnt <= '0;
      end else begin
         if (hit_evt && (o_hit_cnt != 32'hFFFF_FFFF)) begin
            o_hit_cnt <= o_hit_cnt + 32'd1;
         end
         if (miss_evt && (o_miss_cnt != 32'hFFFF_FFFF)) begin
            o_miss_cnt <= o_miss_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_riscq_dcache.sv
// Testbench for riscq_dcache (default parameters). A behavioural 1-cycle
// latency RAM is attached to the RAM port. Each vector is one clock cycle:
// inputs are driven just after the rising edge and outputs are compared at
// the falling edge against hand-computed values.

module tb_riscq_dcache;

   localparam logic [1:0] S_INIT = 2'd0;
   localparam logic [1:0] S_IDLE = 2'd1;
   localparam logic [1:0] S_FILL = 2'd2;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  be;
   logic        we, re, as, halt;
   logic        init_done, init_we;
   logic [11:0] init_waddr;
   logic [31:0] init_wdata;
   logic        ram_en;
   logic [3:0]  ram_we;
   logic [11:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic [1:0]  dbg_state;
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif

   int compared = 0;
   int mismatched = 0;

   riscq_dcache dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_addr       (addr),
      .i_wdata      (wdata),
      .i_be         (be),
      .i_we         (we),
      .i_re         (re),
      .i_as         (as),
      .o_rdata      (rdata),
      .o_halt       (halt),
      .i_init_done  (init_done),
      .i_init_we    (init_we),
      .i_init_waddr (init_waddr),
      .i_init_wdata (init_wdata),
      .o_ram_en     (ram_en),
      .o_ram_we     (ram_we),
      .o_ram_addr   (ram_addr),
      .o_ram_wdata  (ram_wdata),
      .i_ram_rdata  (ram_rdata),
      .dbg_state    (dbg_state)
`ifdef DCACHE_STATS_EN
      ,
      .o_hit_cnt    (hit_cnt),
      .o_miss_cnt   (miss_cnt)
`endif
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- RAM model ----------------
   logic [31:0] mem [0:4095];
   always @(posedge clk) begin
      if (ram_en) begin
         ram_rdata <= mem[ram_addr];
         for (int b = 0; b < 4; b++) begin
            if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
         end
      end
   end

   // ---------------- vector record ----------------
   typedef struct {
      logic        rst, as, re, we;
      logic [31:0] addr, wdata;
      logic [3:0]  be;
      logic        done, iwe;
      logic [11:0] iwa;
      logic [31:0] iwd;
      logic        e_halt;
      logic [31:0] e_rdata;
      logic        e_en;
      logic [3:0]  e_we;
      logic [11:0] e_addr;
      logic [31:0] e_wdata;
      logic [1:0]  e_state;
      logic        chk_stats;
      logic [31:0] e_hit, e_miss;
   } vec_t;

   function automatic vec_t mk(
      input logic r, input logic a, input logic rd, input logic wr,
      input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] b,
      input logic dn, input logic iw, input logic [11:0] iwa, input logic [31:0] iwd,
      input logic eh, input logic [31:0] erd, input logic een, input logic [3:0] ewe,
      input logic [11:0] ead, input logic [31:0] ewd, input logic [1:0] est);
      vec_t v;
      v.rst = r; v.as = a; v.re = rd; v.we = wr; v.addr = ad; v.wdata = wd; v.be = b;
      v.done = dn; v.iwe = iw; v.iwa = iwa; v.iwd = iwd;
      v.e_halt = eh; v.e_rdata = erd; v.e_en = een; v.e_we = ewe;
      v.e_addr = ead; v.e_wdata = ewd; v.e_state = est;
      v.chk_stats = 1'b0; v.e_hit = '0; v.e_miss = '0;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   task automatic apply(input vec_t v, input string name);
      @(posedge clk);
      #1;
      rst = v.rst; as = v.as; re = v.re; we = v.we; addr = v.addr; wdata = v.wdata; be = v.be;
      init_done = v.done; init_we = v.iwe; init_waddr = v.iwa; init_wdata = v.iwd;
      @(negedge clk);
      check({name, ".state"}, {30'd0, dbg_state}, {30'd0, v.e_state});
      check({name, ".halt"}, {31'd0, halt}, {31'd0, v.e_halt});
      check({name, ".rdata"}, rdata, v.e_rdata);
      check({name, ".ram_en"}, {31'd0, ram_en}, {31'd0, v.e_en});
      check({name, ".ram_we"}, {28'd0, ram_we}, {28'd0, v.e_we});
      check({name, ".ram_addr"}, {20'd0, ram_addr}, {20'd0, v.e_addr});
      check({name, ".ram_wdata"}, ram_wdata, v.e_wdata);
`ifdef DCACHE_STATS_EN
      if (v.chk_stats) begin
         check({name, ".hit_cnt"}, hit_cnt, v.e_hit);
         check({name, ".miss_cnt"}, miss_cnt, v.e_miss);
      end
`endif
   endtask

   vec_t vecs[$];
   vec_t v;

   initial begin
      rst = 1'b1; as = 0; re = 0; we = 0; addr = '0; wdata = '0; be = '0;
      init_done = 0; init_we = 0; init_waddr = '0; init_wdata = '0;

      // ---------------- reset state ----------------
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst.state", {30'd0, dbg_state}, {30'd0, S_INIT});
      check("rst.halt", {31'd0, halt}, 32'd0);
      check("rst.rdata", rdata, 32'd0);
      check("rst.ram_en", {31'd0, ram_en}, 32'd0);
      check("rst.ram_we", {28'd0, ram_we}, 32'd0);
      check("rst.ram_addr", {20'd0, ram_addr}, 32'd0);
      check("rst.ram_wdata", ram_wdata, 32'd0);
`ifdef DCACHE_STATS_EN
      check("rst.hit_cnt", hit_cnt, 32'd0);
      check("rst.miss_cnt", miss_cnt, 32'd0);
`endif

      // ---------------- vector table ----------------
      // loader phase: o_halt follows i_as, every init write reaches the RAM
      vecs.push_back(mk(0,1,0,0,32'h0,32'h0,4'h0, 0,1,12'h000,32'h11111111, 1,32'h0,1,4'hF,12'h000,32'h11111111,S_INIT));
      vecs.push_back(mk(0,0,0,0,32'h0,32'h0,4'h0, 0,1,12'h001,32'h22222222, 0,32'h0,1,4'hF,12'h001,32'h22222222,S_INIT));
      vecs.push_back(mk(0,1,1,0,32'h4,32'h0,4'h0, 0,1,12'h002,32'h33333333, 1,32'h0,1,4'hF,12'h002,32'h33333333,S_INIT));
      vecs.push_back(mk(0,0,0,0,32'h0,32'h0,4'h0, 1,1,12'h041,32'h44444444, 0,32'h0,1,4'hF,12'h041,32'h44444444,S_INIT));
      vecs.push_back(mk(0,0,0,0,32'h0,32'h0,4'h0, 0,0,12'h000,32'h0,        0,32'h0,0,4'h0,12'h000,32'h0,S_IDLE));
      // read 0x4: miss, fill, then hit
      vecs.push_back(mk(0,1,1,0,32'h4,32'h0,4'h0, 0,0,12'h0,32'h0, 1,32'h0,1,4'h0,12'h001,32'h0,S_IDLE));
      vecs.push_back(mk(0,1,1,0,32'h4,32'h0,4'h0, 0,0,12'h0,32'h0, 0,32'h22222222,0,4'h0,12'h000,32'h0,S_FILL));
      vecs.push_back(mk(0,1,1,0,32'h4,32'h0,4'h0, 0,0,12'h0,32'h0, 0,32'h22222222,0,4'h0,12'h000,32'h0,S_IDLE));
      // partial write hit, then read the merged word
      v = mk(0,1,0,1,32'h4,32'hAABBCCDD,4'b0101, 0,0,12'h0,32'h0, 0,32'h0,1,4'b0101,12'h001,32'hAABBCCDD,S_IDLE);
      v.chk_stats = 1'b1; v.e_hit = 32'd1; v.e_miss = 32'd1;
      vecs.push_back(v);
      vecs.push_back(mk(0,1,1,0,32'h4,32'h0,4'h0, 0,0,12'h0,32'h0, 0,32'h22BB22DD,0,4'h0,12'h000,32'h0,S_IDLE));
      // same index, different tag: line replaced each time
      vecs.push_back(mk(0,1,1,0,32'h104,32'h0,4'h0, 0,0,12'h0,32'h0, 1,32'h0,1,4'h0,12'h041,32'h0,S_IDLE));
      vecs.push_back(mk(0,1,1,0,32'h104,32'h0,4'h0, 0,0,12'h0,32'h0, 0,32'h44444444,0,4'h0,12'h000,32'h0,S_FILL));
      vecs.push_back(mk(0,1,1,0,32'h4,32'h0,4'h0, 0,0,12'h0,32'h0, 1,32'h0,1,4'h0,12'h001,32'h0,S_IDLE));
      vecs.push_back(mk(0,1,1,0,32'h4,32'h0,4'h0, 0,0,12'h0,32'h0, 0,32'h22BB22DD,0,4'h0,12'h000,32'h0,S_FILL));
      vecs.push_back(mk(0,1,1,0,32'h4,32'h0,4'h0, 0,0,12'h0,32'h0, 0,32'h22BB22DD,0,4'h0,12'h000,32'h0,S_IDLE));
      // re & we together is a write (miss, no allocate), then read it back
      vecs.push_back(mk(0,1,1,1,32'h8,32'h55667788,4'hF, 0,0,12'h0,32'h0, 0,32'h0,1,4'hF,12'h002,32'h55667788,S_IDLE));
      vecs.push_back(mk(0,1,1,0,32'h8,32'h0,4'h0, 0,0,12'h0,32'h0, 1,32'h0,1,4'h0,12'h002,32'h0,S_IDLE));
      vecs.push_back(mk(0,1,1,0,32'h8,32'h0,4'h0, 0,0,12'h0,32'h0, 0,32'h55667788,0,4'h0,12'h000,32'h0,S_FILL));
      // i_be == 0: RAM cycle issued, line untouched
      vecs.push_back(mk(0,1,0,1,32'h8,32'hFFFFFFFF,4'h0, 0,0,12'h0,32'h0, 0,32'h0,1,4'h0,12'h002,32'hFFFFFFFF,S_IDLE));
      vecs.push_back(mk(0,1,1,0,32'h8,32'h0,4'h0, 0,0,12'h0,32'h0, 0,32'h55667788,0,4'h0,12'h000,32'h0,S_IDLE));
      // out of region and idle strobes: nothing happens
      vecs.push_back(mk(0,1,1,0,32'h40000000,32'h0,4'h0, 0,0,12'h0,32'h0, 0,32'h0,0,4'h0,12'h000,32'h0,S_IDLE));
      vecs.push_back(mk(0,1,0,1,32'h40000004,32'h99999999,4'hF, 0,0,12'h0,32'h0, 0,32'h0,0,4'h0,12'h000,32'h0,S_IDLE));
      vecs.push_back(mk(0,0,1,0,32'h4,32'h0,4'h0, 0,0,12'h0,32'h0, 0,32'h0,0,4'h0,12'h000,32'h0,S_IDLE));
      // write miss goes to RAM only; later read must miss and see it
      vecs.push_back(mk(0,1,0,1,32'h10,32'h12345678,4'hF, 0,0,12'h0,32'h0, 0,32'h0,1,4'hF,12'h004,32'h12345678,S_IDLE));
      vecs.push_back(mk(0,1,1,0,32'h10,32'h0,4'h0, 0,0,12'h0,32'h0, 1,32'h0,1,4'h0,12'h004,32'h0,S_IDLE));
      vecs.push_back(mk(0,1,1,0,32'h10,32'h0,4'h0, 0,0,12'h0,32'h0, 0,32'h12345678,0,4'h0,12'h000,32'h0,S_FILL));
      v = mk(0,0,0,0,32'h0,32'h0,4'h0, 0,0,12'h0,32'h0, 0,32'h0,0,4'h0,12'h000,32'h0,S_IDLE);
      v.chk_stats = 1'b1; v.e_hit = 32'd4; v.e_miss = 32'd5;
      vecs.push_back(v);

      foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i + 1));

      // ---------------- reset during FILL ----------------
      apply(mk(0,1,1,0,32'h4,32'h0,4'h0, 0,0,12'h0,32'h0, 0,32'h22BB22DD,0,4'h0,12'h000,32'h0,S_IDLE), "r_hit");
      apply(mk(0,1,1,0,32'h0,32'h0,4'h0, 0,0,12'h0,32'h0, 1,32'h0,1,4'h0,12'h000,32'h0,S_IDLE), "r_miss");
      apply(mk(1,1,1,0,32'h0,32'h0,4'h0, 0,0,12'h0,32'h0, 0,32'h11111111,0,4'h0,12'h000,32'h0,S_FILL), "r_fill_rst");
      v = mk(0,1,1,0,32'h4,32'h0,4'h0, 0,0,12'h0,32'h0, 1,32'h0,0,4'h0,12'h000,32'h0,S_INIT);
      v.chk_stats = 1'b1; v.e_hit = 32'd0; v.e_miss = 32'd0;
      apply(v, "r_init");
      apply(mk(0,0,0,0,32'h0,32'h0,4'h0, 1,0,12'h0,32'h0, 0,32'h0,0,4'h0,12'h000,32'h0,S_INIT), "r_done");
      // previously valid line 1 now misses
      apply(mk(0,1,1,0,32'h4,32'h0,4'h0, 0,0,12'h0,32'h0, 1,32'h0,1,4'h0,12'h001,32'h0,S_IDLE), "r_rd4");
      apply(mk(0,1,1,0,32'h4,32'h0,4'h0, 0,0,12'h0,32'h0, 0,32'h22BB22DD,0,4'h0,12'h000,32'h0,S_FILL), "r_fill4");
      // aborted fill of line 0 left nothing behind
      apply(mk(0,1,1,0,32'h0,32'h0,4'h0, 0,0,12'h0,32'h0, 1,32'h0,1,4'h0,12'h000,32'h0,S_IDLE), "r_rd0");
      apply(mk(0,1,1,0,32'h0,32'h0,4'h0, 0,0,12'h0,32'h0, 0,32'h11111111,0,4'h0,12'h000,32'h0,S_FILL), "r_fill0");
      v = mk(0,0,0,0,32'h0,32'h0,4'h0, 0,0,12'h0,32'h0, 0,32'h0,0,4'h0,12'h000,32'h0,S_IDLE);
      v.chk_stats = 1'b1; v.e_hit = 32'd0; v.e_miss = 32'd2;
      apply(v, "r_end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
